mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the CPU's single memory port between instruction fetch and data load/store traffic. Sits between the fetch/load-store datapath and the memory, alongside the step-sequencing control unit, which raises requests and waits on completion pulses. Accepts one transaction at a time from either requester, drives it to memory, and routes the completion back to its owner. Data has priority, with an optional starvation guard for fetch.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8)
- STREAK, 4, consecutive data grants tolerated before fetch is forced (guard only)

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- if_req / if_addr  in  1 / ADDR_W  fetch request, held with its address until accepted
- if_ready  out  1  fetch request accepted this cycle
- if_rvalid / if_rdata  out  1 / DATA_W  fetch completion pulse and instruction word
- d_req / d_we / d_addr / d_wdata / d_wstrb  in  1 / 1 / ADDR_W / DATA_W / DATA_W/8  data request, held with its payload until accepted
- d_ready  out  1  data request accepted this cycle
- d_rvalid / d_rdata  out  1 / DATA_W  data completion pulse and load data
- mem_req / mem_we / mem_addr / mem_wdata / mem_wstrb  out  per above  memory request
- mem_ack / mem_rdata  in  1 / DATA_W  memory completion pulse; rdata valid with ack

## Operation
- States: IDLE, BUSY. Owner register: FETCH or DATA.
- **IDLE, request pending:**
  - Grant the winner. Its ready is high combinationally this cycle.
  - Latch its payload. Fetch payload is forced to we=0, wstrb=0, wdata=0.
  - Set the owner. Next state is BUSY.
- **IDLE, no request:** stay in IDLE; all readies are 0.
- **Priority:** d_req wins over if_req when both are high. At most one ready is high per cycle.
- **BUSY:**
  - mem_req=1, driven only from registers.
  - mem_* payload is stable until mem_ack.
  - Readies are 0.
- **BUSY with mem_ack:**
  - Register mem_rdata into the owner's rdata; the owner's rvalid is 1 in the next cycle only.
  - Return to IDLE on the same edge.
  - Writes also pulse d_rvalid; d_rdata=0 for writes.
- **rdata outputs:** if_rdata/d_rdata hold their last value between pulses. The non-owner's rvalid stays 0.
- **Ignored inputs:** mem_ack in IDLE is ignored. Requests that drop before ready are ignored; no side effects.
- **Reset:** state→IDLE; all outputs 0; rdata registers 0; streak counter 0.
- **Reset mid-BUSY:** the transaction is abandoned; no rvalid is produced. A mem_ack arriving after reset is ignored.

## Timing
- Cycle 0: req high in IDLE → ready=1.
- Cycle 1 onward: mem_req=1.
- mem_ack at cycle k (k≥1) → owner rvalid at cycle k+1, state IDLE at cycle k+1.
- Minimum turnaround is 2 cycles, accept to rvalid. A new accept can occur in the same cycle as the previous rvalid.
- Throughput: one transaction per 2 cycles with zero-wait memory.

## Configuration
- **MEM_ARB_STARVE_GUARD_EN defined:**
  - A counter of STREAK width, saturating at STREAK, increments on each data grant made while if_req=1.
  - It clears on any fetch grant and on any data grant made while if_req=0.
  - When the counter equals STREAK and if_req=1 in IDLE, fetch wins over d_req.
- **Not defined:** strict data priority; the counter is absent.

## Structure
- Package mem_arb_pkg holds:
  - state enum {IDLE, BUSY}
  - owner enum {OWN_FETCH, OWN_DATA}
  - default parameter constants
- One combinational sub-module, mem_arb_prio: inputs if_req, d_req, and guard_force (tied 0 without the macro); outputs one-hot grant.
- The state register, payload registers, and streak counter live in mem_arbiter.

## Test plan
- Fetch only: if_req=1, if_addr=0x100, mem_ack 3 cycles after accept with rdata=0x00500093 → if_ready at c0; mem_addr=0x100, mem_we=0 during c1–c3; if_rvalid at c4 with if_rdata=0x00500093.
- Collision: if_req and d_req (we=1, addr=0x2000, wdata=0xDEADBEEF, wstrb=0xF) rise together → d_ready first; memory sees the write; d_rvalid with d_rdata=0; fetch accepted in the same cycle as d_rvalid.
- Zero-wait back-to-back: mem_ack on the first BUSY cycle for 4 fetches → ready every 2 cycles; rvalid one cycle after each ack.
- Reset mid-BUSY: reset in the 2nd BUSY cycle, then mem_ack the following cycle → no rvalid; mem_req=0; IDLE after reset.
- Guard (macro on, STREAK=4): d_req and if_req held high continuously → 4 data grants, then 1 fetch grant, repeating. Macro off → no fetch grant while d_req is high.
- Stray mem_ack in IDLE with no requests → no rvalid; no state change.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the CPU memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  typedef enum logic {OWN_FETCH = 1'b0, OWN_DATA = 1'b1} owner_t;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int STREAK_DEF = 4;

  // Bit positions inside the one-hot grant vector.
  localparam int GNT_FETCH = 0;
  localparam int GNT_DATA  = 1;

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational priority pick between fetch and data requests; one-hot grant.
module mem_arb_prio
  import mem_arb_pkg::*;
(
  input  logic       if_req,
  input  logic       d_req,
  input  logic       guard_force,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (guard_force && if_req) begin
      grant[GNT_FETCH] = 1'b1;
    end else if (d_req) begin
      grant[GNT_DATA] = 1'b1;
    end else if (if_req) begin
      grant[GNT_FETCH] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: fetch vs. data, one outstanding transaction.
// Optional fetch starvation guard enabled by MEM_ARB_STARVE_GUARD_EN.
//
// state | meaning
// IDLE  | no transaction; winner granted combinationally, payload latched
// BUSY  | mem_req held from registers until mem_ack
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int STREAK = STREAK_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_ready,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  state_t                r_state;
  state_t                w_next_state;
  owner_t                r_owner;
  logic [ADDR_W-1:0]     r_addr;
  logic                  r_we;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W/8-1:0]   r_wstrb;
  logic                  r_if_rvalid;
  logic [DATA_W-1:0]     r_if_rdata;
  logic                  r_d_rvalid;
  logic [DATA_W-1:0]     r_d_rdata;
  logic [1:0]            w_grant;
  logic                  w_guard_force;

  mem_arb_prio u_prio (
    .if_req      (if_req),
    .d_req       (d_req),
    .guard_force (w_guard_force),
    .grant       (w_grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if_ready     = 1'b0;
    d_ready      = 1'b0;
    case (r_state)
      IDLE: begin
        if_ready = w_grant[GNT_FETCH];
        d_ready  = w_grant[GNT_DATA];
        if (|w_grant) begin
          w_next_state = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner     <= OWN_FETCH;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rvalid  <= 1'b0;
      r_d_rdata   <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      if (d_ready) begin
        r_owner <= OWN_DATA;
        r_addr  <= d_addr;
        r_we    <= d_we;
        r_wdata <= d_wdata;
        r_wstrb <= d_wstrb;
      end else if (if_ready) begin
        // Fetches are always plain reads on the memory side.
        r_owner <= OWN_FETCH;
        r_addr  <= if_addr;
        r_we    <= 1'b0;
        r_wdata <= '0;
        r_wstrb <= '0;
      end
      if (r_state == BUSY && mem_ack) begin
        if (r_owner == OWN_DATA) begin
          r_d_rvalid <= 1'b1;
          r_d_rdata  <= r_we ? '0 : mem_rdata;
        end else begin
          r_if_rvalid <= 1'b1;
          r_if_rdata  <= mem_rdata;
        end
      end
    end
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int                CNT_W    = $clog2(STREAK + 1);
  localparam logic [CNT_W-1:0]  STREAK_C = CNT_W'(STREAK);

  logic [CNT_W-1:0] r_streak;

  // Counts data wins that actually held off a waiting fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_streak <= '0;
    end else if (d_ready) begin
      if (!if_req) begin
        r_streak <= '0;
      end else if (r_streak != STREAK_C) begin
        r_streak <= r_streak + 1'b1;
      end
    end else if (if_ready) begin
      r_streak <= '0;
    end
  end

  assign w_guard_force = (r_state == IDLE) && (r_streak == STREAK_C);
`else
  assign w_guard_force = (STREAK < 0);
`endif

  assign mem_req   = (r_state == BUSY);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wstrb = r_wstrb;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign d_rvalid  = r_d_rvalid;
  assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a latency-programmable memory model
// and a completion scoreboard.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ready, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [3:0]    d_wstrb = '0;
  logic          d_ready, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic          is_data;
    logic [DW-1:0] rdata;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   lat = 0;
  int   wcnt = 0;
  bit   auto_ack = 1'b0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return (a * 32'd7) ^ 32'hA5A5_0000;
  endfunction

  // Advance one clock; the memory model answers from the registered request.
  task automatic tick();
    @(posedge clk);
    #1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    if (auto_ack && mem_req) begin
      if (wcnt >= lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(mem_addr);
        wcnt      = 0;
      end else begin
        wcnt++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    #1;
    n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    n_chk++; if ({if_ready, d_ready} !== 2'b00) begin n_fail++; $display("FAIL rst_ready: got %b want 00", {if_ready, d_ready}); end
    n_chk++; if ({if_rvalid, d_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid: got %b want 00", {if_rvalid, d_rvalid}); end
    n_chk++; if ({if_rdata, d_rdata} !== 64'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", {if_rdata, d_rdata}); end
    n_chk++; if ({mem_we, mem_addr, mem_wdata, mem_wstrb} !== 69'h0) begin n_fail++; $display("FAIL rst_mem_payload: got %h want 0", {mem_we, mem_addr, mem_wdata, mem_wstrb}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fetch_only();
    lat = 2; wcnt = 0; auto_ack = 1'b1;
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    n_chk++; if ({if_ready, d_ready} !== 2'b10) begin n_fail++; $display("FAIL fo_ready: got %b want 10", {if_ready, d_ready}); end
    for (int c = 1; c <= 3; c++) begin
      tick();
      if_req = 1'b0;
      #1;
      n_chk++; if ({mem_req, mem_we, mem_addr, if_ready, if_rvalid} !== {2'b10, 32'h100, 2'b00})
        begin n_fail++; $display("FAIL fo_busy_c%0d: req/we=%b%b addr=%h rdy=%b rv=%b want 1 0 100 0 0", c, mem_req, mem_we, mem_addr, if_ready, if_rvalid); end
    end
    tick();
    #1;
    n_chk++; if ({if_rvalid, d_rvalid, if_rdata} !== {2'b10, 32'h0050_0093}) begin n_fail++; $display("FAIL fo_rvalid: got rv=%b%b rdata=%h want 10 00500093", if_rvalid, d_rvalid, if_rdata); end
    tick();
    #1;
    n_chk++; if ({if_rvalid, if_rdata, mem_req} !== {1'b0, 32'h0050_0093, 1'b0}) begin n_fail++; $display("FAIL fo_hold: got rv=%b rdata=%h req=%b want 0 00500093 0", if_rvalid, if_rdata, mem_req); end
  endtask

  task automatic test_collision();
    lat = 0; wcnt = 0; auto_ack = 1'b1;
    tick();
    if_req = 1'b1; if_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
    #1;
    n_chk++; if ({if_ready, d_ready} !== 2'b01) begin n_fail++; $display("FAIL col_ready: got %b want 01", {if_ready, d_ready}); end
    tick();
    d_req = 1'b0; d_we = 1'b0; d_wdata = '0; d_wstrb = '0;
    #1;
    n_chk++; if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb} !== {2'b11, 32'h2000, 32'hDEAD_BEEF, 4'hF})
      begin n_fail++; $display("FAIL col_write: got %b%b %h %h %h want 1 1 2000 deadbeef f", mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb); end
    tick();
    #1;
    n_chk++; if ({d_rvalid, d_rdata, if_rvalid} !== {1'b1, 32'h0, 1'b0}) begin n_fail++; $display("FAIL col_drvalid: got rv=%b rdata=%h ifrv=%b want 1 0 0", d_rvalid, d_rdata, if_rvalid); end
    n_chk++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL col_fetch_same_cycle: got %b want 1", if_ready); end
    tick();
    if_req = 1'b0;
    #1;
    n_chk++; if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb} !== {2'b10, 32'h300, 32'h0, 4'h0})
      begin n_fail++; $display("FAIL col_fetch_payload: got %b%b %h %h %h want 1 0 300 0 0", mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb); end
    tick();
    #1;
    n_chk++; if ({if_rvalid, if_rdata, d_rvalid} !== {1'b1, mem_word(32'h300), 1'b0}) begin n_fail++; $display("FAIL col_ifrvalid: got rv=%b rdata=%h drv=%b want 1 %h 0", if_rvalid, if_rdata, d_rvalid, mem_word(32'h300)); end
  endtask

  task automatic test_data_read();
    lat = 1; wcnt = 0; auto_ack = 1'b1;
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    #1;
    n_chk++; if ({if_ready, d_ready} !== 2'b01) begin n_fail++; $display("FAIL rd_ready: got %b want 01", {if_ready, d_ready}); end
    tick();
    d_req = 1'b0;
    #1;
    n_chk++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h40}) begin n_fail++; $display("FAIL rd_mem: got %b%b %h want 1 0 40", mem_req, mem_we, mem_addr); end
    tick();
    tick();
    #1;
    n_chk++; if ({d_rvalid, d_rdata, if_rvalid, if_rdata} !== {1'b1, mem_word(32'h40), 1'b0, mem_word(32'h300)})
      begin n_fail++; $display("FAIL rd_rvalid: got drv=%b d=%h ifrv=%b if=%h want 1 %h 0 %h", d_rvalid, d_rdata, if_rvalid, if_rdata, mem_word(32'h40), mem_word(32'h300)); end
  endtask

  task automatic test_back_to_back();
    int   sent;
    int   last_acc;
    exp_t e;
    bit   done;
    sent = 0; last_acc = -1; done = 1'b0;
    lat = 0; wcnt = 0; auto_ack = 1'b1;
    tick();
    if_req = 1'b1; if_addr = 32'h1000;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (if_ready) begin
        if (last_acc >= 0) begin
          n_chk++; if (cyc - last_acc != 2) begin n_fail++; $display("FAIL b2b_spacing: got %0d cycles want 2", cyc - last_acc); end
        end
        e.is_data = 1'b0; e.rdata = mem_word(if_addr); e.cyc = cyc + 2;
        sb.push_back(e);
        sent++; last_acc = cyc;
      end
      if (if_rvalid || d_rvalid) begin
        n_chk++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL b2b_unexpected_rvalid: got if=%b d=%b want none", if_rvalid, d_rvalid); end
        else begin
          e = sb.pop_front();
          if ({d_rvalid, if_rvalid, if_rdata} !== {2'b01, e.rdata} || cyc != e.cyc) begin
            n_fail++; $display("FAIL b2b_rvalid: got drv=%b ifrv=%b rdata=%h cyc=%0d want 0 1 %h cyc=%0d", d_rvalid, if_rvalid, if_rdata, cyc, e.rdata, e.cyc);
          end
        end
      end
      done = (sent >= 4) && (sb.size() == 0);
      tick();
      if (sent >= 4) if_req = 1'b0;
      else if_addr = 32'h1000 + 32'(4 * sent);
    end
    n_chk++; if (!done) begin n_fail++; $display("FAIL b2b_timeout: got %0d sent %0d pending want 4 sent 0 pending", sent, sb.size()); end
  endtask

  task automatic test_guard();
    int   grants;
    logic exp_f;
    logic gf, gd;
    exp_t e;
    bit   done;
    grants = 0; done = 1'b0;
    lat = 0; wcnt = 0; auto_ack = 1'b1;
    if_req = 1'b1; if_addr = 32'h3000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000; d_wstrb = '0; d_wdata = '0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      #1;
      gf = if_ready; gd = d_ready;
      if (gf || gd) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_f = (grants % 5 == 4);
`else
        exp_f = 1'b0;
`endif
        n_chk++; if ({gf, gd} !== {exp_f, ~exp_f}) begin n_fail++; $display("FAIL guard_grant%0d: got if=%b d=%b want if=%b", grants, gf, gd, exp_f); end
        e.is_data = gd; e.rdata = mem_word(gd ? d_addr : if_addr); e.cyc = cyc + 2;
        sb.push_back(e);
        grants++;
      end
      if (if_rvalid || d_rvalid) begin
        n_chk++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL guard_unexpected_rvalid: got if=%b d=%b want none", if_rvalid, d_rvalid); end
        else begin
          e = sb.pop_front();
          if ({d_rvalid, if_rvalid} !== {e.is_data, ~e.is_data} || (e.is_data ? d_rdata : if_rdata) !== e.rdata || cyc != e.cyc) begin
            n_fail++; $display("FAIL guard_rvalid: got drv=%b ifrv=%b d=%h if=%h cyc=%0d want data=%b %h cyc=%0d", d_rvalid, if_rvalid, d_rdata, if_rdata, cyc, e.is_data, e.rdata, e.cyc);
          end
        end
      end
      done = (grants >= 10) && (sb.size() == 0);
      tick();
      if (gf) if_addr = if_addr + 32'd4;
      if (gd) d_addr = d_addr + 32'd4;
      if (grants >= 10) begin if_req = 1'b0; d_req = 1'b0; end
    end
    n_chk++; if (!done) begin n_fail++; $display("FAIL guard_timeout: got %0d grants %0d pending want 10 grants 0 pending", grants, sb.size()); end
  endtask

  task automatic test_reset_mid_busy();
    auto_ack = 1'b0;
    tick();
    if_req = 1'b1; if_addr = 32'h500;
    #1;
    n_chk++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL rmb_ready: got %b want 1", if_ready); end
    tick();
    if_req = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    n_chk++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rmb_busy2: got %b want 1", mem_req); end
    tick();
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    #1;
    n_chk++; if ({mem_req, if_rvalid, d_rvalid} !== 3'b000) begin n_fail++; $display("FAIL rmb_after_reset: got %b want 000", {mem_req, if_rvalid, d_rvalid}); end
    tick();
    #1;
    n_chk++; if ({mem_req, if_rvalid, d_rvalid, if_rdata, d_rdata} !== 67'h0) begin n_fail++; $display("FAIL rmb_stray_ack: got req=%b rv=%b%b if=%h d=%h want all 0", mem_req, if_rvalid, d_rvalid, if_rdata, d_rdata); end
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    #1;
    n_chk++; if (d_ready !== 1'b1) begin n_fail++; $display("FAIL rmb_idle_accept: got %b want 1", d_ready); end
    lat = 0; wcnt = 0; auto_ack = 1'b1;
    tick();
    d_req = 1'b0;
    tick();
    #1;
    n_chk++; if ({d_rvalid, d_rdata} !== {1'b1, mem_word(32'h600)}) begin n_fail++; $display("FAIL rmb_recover: got %b %h want 1 %h", d_rvalid, d_rdata, mem_word(32'h600)); end
  endtask

  task automatic test_stray_ack();
    auto_ack = 1'b0;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    n_chk++; if ({if_ready, d_ready, mem_req} !== 3'b000) begin n_fail++; $display("FAIL stray_idle: got %b want 000", {if_ready, d_ready, mem_req}); end
    tick();
    #1;
    n_chk++; if ({if_rvalid, d_rvalid, mem_req, if_rdata, d_rdata} !== {3'b000, 32'h0, mem_word(32'h600)})
      begin n_fail++; $display("FAIL stray_outputs: got rv=%b%b req=%b if=%h d=%h want 000 0 %h", if_rvalid, d_rvalid, mem_req, if_rdata, d_rdata, mem_word(32'h600)); end
    if_req = 1'b1; if_addr = 32'h700;
    #1;
    n_chk++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL stray_still_idle: got %b want 1", if_ready); end
    tick();
    if_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_collision();
    test_data_read();
    test_back_to_back();
    test_guard();
    test_reset_mid_busy();
    test_stray_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
